// File: rtl/phase_sequencer_pkg.sv
// rtl/phase_sequencer_pkg.sv - shared state encoding and widths for the phase sequencer
package phase_sequencer_pkg;

  localparam int OPW = 8;
  localparam int PCW = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_PH1  = 3'd2,
    S_PH2  = 3'd3,
    S_PH3  = 3'd4,
    S_CAPT = 3'd5
  } state_t;

endpackage

// File: rtl/phase_sequencer_if.sv
// rtl/phase_sequencer_if.sv - operand, strobe and result bundle between sequencer and its user
// Optional err signal present when PHASE_SEQ_ERR_EN is defined.
interface phase_sequencer_if;
  import phase_sequencer_pkg::*;

  logic           start;
  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic [OPW-1:0] a_drv;
  logic [OPW-1:0] b_drv;
  logic           t0;
  logic           t1;
  logic           t2;
  logic           t3;
  logic [OPW-1:0] result_in;
  logic [OPW-1:0] result;
  logic           busy;
  logic           done;
`ifdef PHASE_SEQ_ERR_EN
  logic           err;

  modport master (
    output start, op_a, op_b, result_in,
    input  a_drv, b_drv, t0, t1, t2, t3, result, busy, done, err
  );
  modport slave (
    input  start, op_a, op_b, result_in,
    output a_drv, b_drv, t0, t1, t2, t3, result, busy, done, err
  );
`else
  modport master (
    output start, op_a, op_b, result_in,
    input  a_drv, b_drv, t0, t1, t2, t3, result, busy, done
  );
  modport slave (
    input  start, op_a, op_b, result_in,
    output a_drv, b_drv, t0, t1, t2, t3, result, busy, done
  );
`endif

endinterface

// File: rtl/phase_sequencer_timer.sv
// rtl/phase_sequencer_timer.sv - loadable down-counter timing each phase
// tc is high while the count sits at zero, i.e. in the last cycle of a phase.
module phase_timer
  import phase_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [PCW-1:0] load_val,
  output logic           tc
);

  logic [PCW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - four-phase strobe sequencer driving a gate array and capturing its result
// Define PHASE_SEQ_ERR_EN to add the sticky err output (start seen while busy).
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int PHASE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  phase_sequencer_if.slave   bus
);

  localparam logic [PCW-1:0] RELOAD = PCW'(PHASE_CYCLES - 1);

  state_t state;
  state_t next_state;
  logic   tc;
  logic   load;
  logic   accept;
  logic   t0_d, t1_d, t2_d, t3_d, busy_d, done_d;

  assign accept = (state == S_IDLE) && bus.start;
  assign load   = (next_state != state);

  phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (RELOAD),
    .tc       (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.start) next_state = S_CLR;
      S_CLR:   if (tc) next_state = S_PH1;
      S_PH1:   if (tc) next_state = S_PH2;
      S_PH2:   if (tc) next_state = S_PH3;
      S_PH3:   if (tc) next_state = S_CAPT;
      S_CAPT:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from next_state so the registered strobes line up with the state.
  always_comb begin
    t0_d   = (next_state == S_CLR);
    t1_d   = (next_state == S_PH1);
    t2_d   = (next_state == S_PH2);
    t3_d   = (next_state == S_PH3);
    busy_d = (next_state != S_IDLE);
    done_d = (next_state == S_CAPT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.t0    <= 1'b0;
      bus.t1    <= 1'b0;
      bus.t2    <= 1'b0;
      bus.t3    <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.a_drv <= '0;
      bus.b_drv <= '0;
      bus.result <= '0;
    end else begin
      bus.t0   <= t0_d;
      bus.t1   <= t1_d;
      bus.t2   <= t2_d;
      bus.t3   <= t3_d;
      bus.busy <= busy_d;
      bus.done <= done_d;
      if (accept) begin
        bus.a_drv <= bus.op_a;
        bus.b_drv <= bus.op_b;
      end
      if (state == S_PH3 && tc) begin
        bus.result <= bus.result_in;
      end
    end
  end

`ifdef PHASE_SEQ_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.err <= 1'b0;
    end else if (accept) begin
      bus.err <= 1'b0;
    end else if (bus.start && bus.busy) begin
      bus.err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - checks two sequencer instances (1 and 3 cycles per phase) against an elapsed-cycle model
module tb_phase_sequencer;

  localparam int P0 = 1;
  localparam int P1 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic [7:0] result_in = 8'h00;

  int checks = 0;
  int errors = 0;
  int phase = 0;

  always #5 clk = ~clk;

  phase_sequencer_if if0 ();
  phase_sequencer_if if1 ();

  assign if0.start = start;
  assign if0.op_a = op_a;
  assign if0.op_b = op_b;
  assign if0.result_in = result_in;
  assign if1.start = start;
  assign if1.op_a = op_a;
  assign if1.op_b = op_b;
  assign if1.result_in = result_in;

  phase_sequencer #(.PHASE_CYCLES(P0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  phase_sequencer #(.PHASE_CYCLES(P1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic [3:0] d_t[2];
  logic [7:0] d_a[2];
  logic [7:0] d_b[2];
  logic [7:0] d_r[2];
  logic       d_busy[2];
  logic       d_done[2];
  assign d_t[0] = {if0.t3, if0.t2, if0.t1, if0.t0};
  assign d_t[1] = {if1.t3, if1.t2, if1.t1, if1.t0};
  assign d_a[0] = if0.a_drv;
  assign d_a[1] = if1.a_drv;
  assign d_b[0] = if0.b_drv;
  assign d_b[1] = if1.b_drv;
  assign d_r[0] = if0.result;
  assign d_r[1] = if1.result;
  assign d_busy[0] = if0.busy;
  assign d_busy[1] = if1.busy;
  assign d_done[0] = if0.done;
  assign d_done[1] = if1.done;
`ifdef PHASE_SEQ_ERR_EN
  logic d_err[2];
  assign d_err[0] = if0.err;
  assign d_err[1] = if1.err;
`endif

  function automatic int pcyc(input int i);
    return (i == 0) ? P0 : P1;
  endfunction

  // Model: n = cycles elapsed since acceptance (0 when idle); phase k spans n in (k*p, (k+1)*p].
  int         n[2];
  logic [7:0] m_a[2];
  logic [7:0] m_b[2];
  logic [7:0] m_r[2];
  logic       m_err[2];
  int         cyc = 0;
  int         acc_cyc[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        n[i] = 0;
        m_a[i] = 8'h00;
        m_b[i] = 8'h00;
        m_r[i] = 8'h00;
        m_err[i] = 1'b0;
        acc_cyc[i] = 0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        int p;
        p = pcyc(i);
        if (n[i] == 0) begin
          if (start) begin
            n[i] = 1;
            m_a[i] = op_a;
            m_b[i] = op_b;
            m_err[i] = 1'b0;
            acc_cyc[i] = cyc;
          end
        end else begin
          if (start) m_err[i] = 1'b1;
          if (n[i] == 4 * p) m_r[i] = result_in;
          n[i] = (n[i] == 4 * p + 1) ? 0 : n[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s inst%0d cycle %0d: got 0x%0h expected 0x%0h", name, inst, cyc, act, exp);
    end
  endtask

  int last_done[2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int p;
      logic [3:0] e_t;
      p = pcyc(i);
      for (int k = 0; k < 4; k++) e_t[k] = (n[i] > k * p) && (n[i] <= (k + 1) * p);
      chk("strobes", i, int'(d_t[i]), int'(e_t));
      chk("onehot", i, int'($countones(d_t[i]) <= 1), 1);
      chk("busy", i, int'(d_busy[i]), int'(n[i] != 0));
      chk("done", i, int'(d_done[i]), int'(n[i] == 4 * p + 1));
      chk("a_drv", i, int'(d_a[i]), int'(m_a[i]));
      chk("b_drv", i, int'(d_b[i]), int'(m_b[i]));
      chk("result", i, int'(d_r[i]), int'(m_r[i]));
`ifdef PHASE_SEQ_ERR_EN
      chk("err", i, int'(d_err[i]), int'(m_err[i]));
`endif
      if (d_done[i] && phase == 1) begin
        chk("latency_lit", i, cyc - acc_cyc[i] + 1, (i == 0) ? 5 : 13);
        chk("result_lit", i, int'(d_r[i]), (i == 0) ? 'h24 : 'h77);
        chk("a_drv_lit", i, int'(d_a[i]), 'hA5);
      end
      if (phase == 4) begin
        if (d_done[i]) begin
          if (last_done[i] > 0) chk("spacing_lit", i, cyc - last_done[i], (i == 0) ? 6 : 14);
          last_done[i] = cyc;
        end
      end else begin
        last_done[i] = 0;
      end
    end
  end

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);

    // Directed run: operand and result_in changes while busy.
    phase = 1;
    start = 1'b1; op_a = 8'hA5; op_b = 8'h3C; result_in = 8'h24;
    step(1);
    start = 1'b0;
    step(3);
    op_a = 8'hFF;
    step(2);
    result_in = 8'h77;
    step(16);

    // start during PH2 of the P=1 instance.
    phase = 2;
    op_a = 8'h11; op_b = 8'h22;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(16);

    // Reset in PH1, then a clean evaluation.
    phase = 3;
    op_a = 8'h5A; op_b = 8'hC3; result_in = 8'h99;
    start = 1'b1;
    step(1);
    start = 1'b0;
    rst_pulse();
    step(2);
    op_a = 8'h42; result_in = 8'h18;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(16);

    // start held continuously.
    phase = 4;
    start = 1'b1;
    step(50);
    start = 1'b0;
    step(16);

    phase = 5;
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(3) == 0);
      op_a = 8'($urandom);
      op_b = 8'($urandom);
      result_in = 8'($urandom);
      if ($urandom_range(99) == 0) rst_pulse();
      step(1);
    end
    start = 1'b0;
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 1, clock cycles each phase is held (legal 1..15).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one evaluation; sampled only in IDLE.
REQ-005 SHALL have port op_a  input  8  operand A, captured on start acceptance.
REQ-006 SHALL have port op_b  input  8  operand B, captured on start acceptance.
REQ-007 SHALL have port a_drv  output  8  held operand A to gate array.
REQ-008 SHALL have port b_drv  output  8  held operand B to gate array.
REQ-009 SHALL have ports t0, t1, t2, t3  output  1 each  phase strobes to gate array (t0 = latch clear).
REQ-010 SHALL have port result_in  input  8  gate-array outputs (Y of each bit cell).
REQ-011 SHALL have port result  output  8  registered evaluation result.
REQ-012 SHALL have port busy  output  1  high from acceptance through the done cycle.
REQ-013 SHALL have port done  output  1  one-cycle pulse, result valid.

Function
REQ-014 SHALL implement FSM IDLE -> CLR -> PH1 -> PH2 -> PH3 -> CAPT -> IDLE.
REQ-015 IDLE with start=1 SHALL register op_a/op_b into a_drv/b_drv and enter CLR next cycle.
REQ-016 CLR, PH1, PH2, PH3 SHALL each last exactly PHASE_CYCLES cycles, via a phase counter reloaded on every state change.
REQ-017 t0 SHALL be high only in CLR, t1 only in PH1, t2 only in PH2, t3 only in PH3; strobes registered, at most one high in any cycle, all low in IDLE and CAPT.
REQ-018 result SHALL load result_in at the clock edge ending the last PH3 cycle; result holds otherwise.
REQ-019 done SHALL be high for exactly the one CAPT cycle; latency from start-accept edge to done high = 4*PHASE_CYCLES+1 cycles.
REQ-020 busy SHALL be high in CLR..CAPT inclusive and low in IDLE.
REQ-021 start while busy SHALL be ignored; start held high in the CAPT cycle SHALL NOT be accepted until IDLE (back-to-back spacing >= 4*PHASE_CYCLES+2 cycles).
REQ-022 a_drv/b_drv SHALL remain constant from acceptance until the next acceptance.
REQ-023 Changes on op_a/op_b while busy SHALL NOT affect a_drv, b_drv or result.

Reset
REQ-024 rst high SHALL immediately force IDLE, t0..t3=0, busy=0, done=0, result=0, a_drv=0, b_drv=0, phase counter=0.
REQ-025 rst asserted mid-evaluation SHALL abort it with no done pulse; first start after rst release SHALL behave as from power-up.

Configuration
REQ-026 Macro PHASE_SEQ_ERR_EN SHALL add output err (1 bit): set when start=1 while busy=1, sticky until next accepted start or rst, reset value 0.
REQ-027 Without PHASE_SEQ_ERR_EN, port err and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding (6 states, 3-bit), operand width constant (8) and phase-counter width (4).
REQ-029 One sub-module phase_timer SHALL implement the loadable down-counter, outputting a terminal-count flag; FSM remains in phase_sequencer.

Verification
REQ-030 PHASE_CYCLES=1, start with op_a=8'hA5, op_b=8'h3C, result_in=8'h24 -> t0,t1,t2,t3 each high one cycle in order, done at cycle 5, result=8'h24, a_drv=8'hA5.
REQ-031 PHASE_CYCLES=3 -> each strobe high 3 cycles, never two strobes high together, done 13 cycles after acceptance.
REQ-032 start pulsed during PH2 -> ignored, single done; with PHASE_SEQ_ERR_EN err=1 until next accepted start.
REQ-033 rst pulsed during PH1 -> all outputs 0 asynchronously, no done; next start completes normally.
REQ-034 start held high continuously -> evaluations repeat with done pulses spaced exactly 4*PHASE_CYCLES+2 cycles.
REQ-035 op_a changed to 8'hFF during PH3 -> a_drv stays 8'hA5; result_in changed after PH3 -> result unchanged.
